// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Two-port arbiter sharing one single-ported memory through a
//            req/ack handshake. Optional counters are compiled in with
//            ARB_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              sel,
    output logic              busy
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sel;
    logic              r_last_grant;
    logic              r_p0_done;
    logic              r_p1_done;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any_valid;
    logic              w_grant;
    logic              w_in_busy;

    assign w_any_valid = p0_valid | p1_valid;
    // Contention: round-robin flips away from the last winner, otherwise port 0.
    assign w_grant = (p0_valid && p1_valid) ? ((RR_EN != 0) ? ~r_last_grant : 1'b0)
                                            : p1_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
            r_p0_done    <= 1'b0;
            r_p1_done    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_sel        <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_rdata   <= mem_rdata;
                        r_p0_done <= ~r_sel;
                        r_p1_done <= r_sel;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_in_busy = (r_state == S_BUSY);
    assign mem_req   = w_in_busy;
    assign mem_we    = w_in_busy & (r_sel ? p1_we : p0_we);
    assign mem_addr  = r_sel ? p1_addr  : p0_addr;
    assign mem_wdata = r_sel ? p1_wdata : p0_wdata;
    assign sel       = r_sel;
    assign busy      = (r_state != S_IDLE);
    assign p0_done   = r_p0_done;
    assign p1_done   = r_p1_done;
    assign rdata     = r_rdata;

`ifdef ARB_PERF_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    // In IDLE nobody is being served yet; in BUSY only the unselected port waits.
    assign w_stall = ((r_state == S_IDLE) && w_any_valid) ||
                     (w_in_busy && (r_sel ? p0_valid : p1_valid));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any_valid) begin
                if (w_grant) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
                else         r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
